uart_byte_receiver: RTL

Serial-to-parallel UART receive stage that sits directly upstream of the UART command accumulator. It recovers 8-bit characters from the asynchronous `rx` line (8N1, or 8E1 when parity is compiled in) and presents each good byte on `data_out` with a fixed-width `data_valid` strobe. The strobe has a clean rising and falling edge, so it drives the accumulator's `accumulate` input directly. Line errors are flagged and the byte is discarded.

---
 rtl/uart_byte_receiver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_byte_receiver.sv
// UART receive stage: 8N1 by default, 8E1 with parity checking when UART_RX_PARITY_EN is defined.
// Good bytes appear on data_out with a data_valid strobe of STROBE_CYCLES clocks; bad frames are flagged and dropped.
module uart_byte_receiver #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned STROBE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_error,
    output logic       parity_error,
    output logic       busy
);

    localparam logic [15:0] HALF_LAST  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] STROBE_LEN = 16'(STROBE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rxs;
    logic        rxs_d;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [15:0] strobe_cnt;
    logic        stop_ok;

    // Synchronizer and edge-history flops idle high so reset never fakes a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_comb begin
        stop_ok = 1'b0;
        if (state == STOP && bit_cnt == BIT_LAST && rxs)
            stop_ok = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            data_out      <= '0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            busy          <= 1'b0;
        end else begin
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rxs_d && !rxs) begin
                        bit_cnt <= '0;
                        state   <= START;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            bit_cnt <= '0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        shift[bit_idx] <= rxs;
                        bit_cnt        <= '0;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rxs != ^shift) begin
                            parity_error <= 1'b1;
                            state        <= WAIT_HIGH;
                        end else begin
                            state <= STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rxs) begin
                            data_out <= shift;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= WAIT_HIGH;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_error = 1'b0;
`endif

    // Strobe runs independently so a new start bit can be caught while it is still high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_cnt <= '0;
            data_valid <= 1'b0;
        end else if (stop_ok) begin
            strobe_cnt <= STROBE_LEN;
            data_valid <= 1'b1;
        end else if (strobe_cnt != '0) begin
            strobe_cnt <= strobe_cnt - 16'd1;
            data_valid <= (strobe_cnt > 16'd1);
        end
    end

endmodule
